// File: rtl/req_encoder_if.sv
// req_encoder_if: request/grant bundle between the requesting/consuming side and req_encoder.
interface req_encoder_if #(
    parameter int N = 3,
    parameter int M = 8
);
    logic [M-1:0] req;
    logic         ready;
    logic         valid;
    logic [N-1:0] idx;
    logic [M-1:0] pending;
    logic         overflow;
    modport master (output req, ready, input valid, idx, pending, overflow);
    modport slave (input req, ready, output valid, idx, pending, overflow);
endinterface

// File: rtl/req_encoder.sv
// req_encoder: queues one-hot requests and hands them out as binary indices over valid/ready.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection; default is lowest index first.
module req_encoder #(
    parameter int N = 3,
    parameter int M = 8
) (
    input logic          clk,
    input logic          reset_n,
    req_encoder_if.slave bus
);
    localparam int W = (M > 2) ? $clog2(M) : 1;
    logic [M-1:0] pending;
    logic [M-1:0] sel_onehot;
    logic [M-1:0] next_pending;
    logic [N-1:0] idx;
    logic [N-1:0] sel_idx;
    logic         valid;
    logic         overflow;
    logic         load;
    int           start;
    // Scan offsets high to low so the lowest offset from start wins.
    function automatic logic [N-1:0] first_set(input logic [M-1:0] p, input int from);
        int j;
        first_set = '0;
        for (int k = M - 1; k >= 0; k--) begin
            j = from + k;
            if (j >= M) j = j - M;
            if (p[j[W-1:0]]) first_set = N'(j);
        end
    endfunction
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [N-1:0] ptr;
    assign start = int'(ptr) + 1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr <= N'(M - 1);
        else if (load) ptr <= sel_idx;
    end
`else
    assign start = 0;
`endif
    always_comb begin
        sel_idx      = first_set(pending, start);
        load         = (!valid || bus.ready) && |pending;
        sel_onehot   = load ? M'(1) << sel_idx : '0;
        next_pending = (pending & ~sel_onehot) | bus.req;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            valid    <= 1'b0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= next_pending;
            overflow <= |(bus.req & pending & ~sel_onehot);
            valid    <= load || (valid && !bus.ready);
            idx      <= load ? sel_idx : idx;
        end
    end
    assign bus.valid    = valid;
    assign bus.idx      = idx;
    assign bus.pending  = pending;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: directed scenarios plus random traffic checked against a queue-level model.
module tb_req_encoder;
    localparam int N = 3;
    localparam int M = 8;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    bit [M-1:0] m_pend;
    bit m_valid;
    bit m_ovf;
    int m_idx;
    int m_ptr;
    req_encoder_if #(.N(N), .M(M)) bus ();
    req_encoder #(.N(N), .M(M)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic want(input string t, input logic v, input logic [M-1:0] p, input logic o);
        chk({t, ".valid"}, 32'(bus.valid), 32'(v));
        chk({t, ".pending"}, 32'(bus.pending), 32'(p));
        chk({t, ".overflow"}, 32'(bus.overflow), 32'(o));
    endtask
    task automatic model_reset();
        m_pend = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_idx = 0;
        m_ptr = M - 1;
    endtask
    // One clock edge of the request queue, computed directly from the grant rules.
    task automatic model_step(input logic [M-1:0] r, input logic rd);
        int sel;
        int from;
        bit load;
        bit [M-1:0] nxt;
        sel = -1;
        from = RR ? (m_ptr + 1) % M : 0;
        load = (!m_valid || rd) && (m_pend != 0);
        if (load)
            for (int k = 0; k < M; k++)
                if (sel < 0 && m_pend[(from + k) % M]) sel = (from + k) % M;
        m_ovf = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (r[i] && m_pend[i] && i != sel) m_ovf = 1'b1;
            nxt[i] = (m_pend[i] && i != sel) || r[i];
        end
        m_pend = nxt;
        if (load) begin
            m_valid = 1'b1;
            m_idx = sel;
            m_ptr = sel;
        end else if (m_valid && rd) begin
            m_valid = 1'b0;
        end
    endtask
    task automatic check_model();
        chk("model.valid", 32'(bus.valid), 32'(m_valid));
        chk("model.idx", 32'(bus.idx), 32'(m_idx));
        chk("model.pending", 32'(bus.pending), 32'(m_pend));
        chk("model.overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask
    task automatic cycle(input logic [M-1:0] r, input logic rd);
        bus.req = r;
        bus.ready = rd;
        @(posedge clk);
        model_step(r, rd);
        @(negedge clk);
        check_model();
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.req = '0;
        bus.ready = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    initial begin
        bus.req = '0;
        bus.ready = 1'b0;
        do_reset();
        want("reset", 1'b0, 8'h00, 1'b0);
        chk("reset.idx", 32'(bus.idx), 32'd0);
        // single request: pending, then granted, then idle
        do_reset();
        cycle(8'h01, 1'b1); want("single.e1", 1'b0, 8'h01, 1'b0);
        cycle(8'h00, 1'b1); want("single.e2", 1'b1, 8'h00, 1'b0);
        chk("single.idx", 32'(bus.idx), 32'd0);
        cycle(8'h00, 1'b1); want("single.e3", 1'b0, 8'h00, 1'b0);
        // three requests drained back to back
        do_reset();
        cycle(8'h92, 1'b1); want("burst.e1", 1'b0, 8'h92, 1'b0);
        cycle(8'h00, 1'b1); want("burst.e2", 1'b1, 8'h90, 1'b0);
        chk("burst.idx1", 32'(bus.idx), 32'd1);
        cycle(8'h00, 1'b1); want("burst.e3", 1'b1, 8'h80, 1'b0);
        chk("burst.idx4", 32'(bus.idx), 32'd4);
        cycle(8'h00, 1'b1); want("burst.e4", 1'b1, 8'h00, 1'b0);
        chk("burst.idx7", 32'(bus.idx), 32'd7);
        cycle(8'h00, 1'b1); want("burst.e5", 1'b0, 8'h00, 1'b0);
        // backpressure holds idx while a new request queues
        do_reset();
        cycle(8'h08, 1'b1);
        cycle(8'h00, 1'b0); want("hold.load", 1'b1, 8'h00, 1'b0);
        chk("hold.idx0", 32'(bus.idx), 32'd3);
        cycle(8'h01, 1'b0); want("hold.post", 1'b1, 8'h01, 1'b0);
        chk("hold.idx1", 32'(bus.idx), 32'd3);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h00, 1'b0);
            chk("hold.idxk", 32'(bus.idx), 32'd3);
        end
        cycle(8'h00, 1'b1); want("hold.next", 1'b1, 8'h00, 1'b0);
        chk("hold.idx_next", 32'(bus.idx), 32'd0);
        cycle(8'h00, 1'b1); want("hold.idle", 1'b0, 8'h00, 1'b0);
        // merge into an already pending bit
        do_reset();
        cycle(8'h21, 1'b0); want("merge.e1", 1'b0, 8'h21, 1'b0);
        cycle(8'h00, 1'b0); want("merge.e2", 1'b1, 8'h20, 1'b0);
        chk("merge.idx0", 32'(bus.idx), 32'd0);
        cycle(8'h20, 1'b0); want("merge.pulse", 1'b1, 8'h20, 1'b1);
        cycle(8'h00, 1'b0); want("merge.after", 1'b1, 8'h20, 1'b0);
        cycle(8'h00, 1'b1); want("merge.grant", 1'b1, 8'h00, 1'b0);
        chk("merge.idx5", 32'(bus.idx), 32'd5);
        cycle(8'h00, 1'b1); want("merge.once", 1'b0, 8'h00, 1'b0);
        // request for the bit being selected on the same edge
        do_reset();
        cycle(8'h20, 1'b0);
        cycle(8'h20, 1'b0); want("same.e2", 1'b1, 8'h20, 1'b0);
        chk("same.idx", 32'(bus.idx), 32'd5);
        cycle(8'h00, 1'b1); want("same.e3", 1'b1, 8'h00, 1'b0);
        chk("same.idx2", 32'(bus.idx), 32'd5);
        cycle(8'h00, 1'b1); want("same.idle", 1'b0, 8'h00, 1'b0);
        // all requests held high: selection order
        do_reset();
        cycle(8'hFF, 1'b1); want("all.e1", 1'b0, 8'hFF, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(8'hFF, 1'b1);
            chk("all.valid", 32'(bus.valid), 32'd1);
            chk("all.idx", 32'(bus.idx), RR ? 32'(k % M) : 32'd0);
        end
        repeat (10) cycle(8'h00, 1'b1);
        // asynchronous reset between edges while busy
        do_reset();
        cycle(8'h0D, 1'b1);
        cycle(8'h00, 1'b0); want("async.pre", 1'b1, 8'h0C, 1'b0);
        cycle(8'h04, 1'b0); want("async.ovf", 1'b1, 8'h0C, 1'b1);
        #2 reset_n = 1'b0;
        #1 want("async.now", 1'b0, 8'h00, 1'b0);
        chk("async.idx", 32'(bus.idx), 32'd0);
        model_reset();
        @(negedge clk);
        check_model();
        reset_n = 1'b1;
        // random traffic against the model
        cycle(8'h00, 1'b1);
        for (int k = 0; k < 400; k++)
            cycle(8'($urandom & $urandom), $urandom_range(0, 3) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 Parameter N, default 3: width of the binary index output.
REQ-002 Parameter M, default 8: number of one-hot request lines; SHALL satisfy 2 <= M <= 2**N.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  M  request bits; each bit high in a cycle posts one request for that index; several bits may be high together.
REQ-006 ready  input  1  consumer accepts the current index this cycle.
REQ-007 valid  output  1  idx holds a granted request.
REQ-008 idx  output  N  binary index of the granted request.
REQ-009 pending  output  M  registered vector of posted but not yet granted requests.
REQ-010 overflow  output  1  one-cycle pulse: a posted request merged into an already-pending bit.

Function
REQ-011 The pending register SHALL update each edge as next_pending = (pending & ~sel_onehot) | req, where sel_onehot is the bit loaded into the output stage that edge, or zero if none is loaded.
REQ-012 The output stage (valid, idx) SHALL load when (!valid || ready) and pending != 0; it then sets valid=1, idx=binary(selected bit), and clears that bit per REQ-011.
REQ-013 When (valid && ready) and pending == 0, valid SHALL go to 0 at the edge.
REQ-014 While valid && !ready, idx and valid SHALL hold unchanged.
REQ-015 A transfer occurs on every edge with valid && ready; back-to-back transfers SHALL sustain one index per cycle while pending is non-zero.
REQ-016 Latency: a req bit sampled at edge k appears in pending after edge k and on idx/valid no earlier than after edge k+1.
REQ-017 idx SHALL be the binary encoding of exactly one pending bit; it never encodes an index >= M.
REQ-018 Simultaneous event: if req sets the same bit that is being selected that edge, the bit SHALL remain pending, counting as a new request, and overflow SHALL NOT pulse.
REQ-019 If req sets a bit that is already pending and not selected that edge, the requests SHALL merge into one and overflow SHALL be 1 for the following cycle only.
REQ-020 Selection order SHALL be defined by REQ-026 and REQ-027.
REQ-021 ready while valid == 0 SHALL have no effect.

Reset
REQ-022 While reset_n == 0, regardless of clk: pending=0, valid=0, idx=0, overflow=0.
REQ-023 While reset_n == 0, the round-robin pointer SHALL be M-1.
REQ-024 Reset asserted mid-transfer SHALL discard the held index and all pending requests; no transfer is counted on that edge.
REQ-025 After release, the first edge SHALL sample req normally.

Configuration
REQ-026 With macro REQ_ENCODER_ROUND_ROBIN_EN defined: a pointer register holds the last loaded index, and selection picks the first pending bit searching upward from pointer+1, wrapping from M-1 to 0.
REQ-027 Without REQ_ENCODER_ROUND_ROBIN_EN: fixed priority, lowest pending index first; no pointer register is built.

Verification
REQ-028 The bench SHALL cover: reset, then req=8'h01 for one cycle with ready=1 -> pending=8'h01 after edge 1; valid=1, idx=0 after edge 2; valid=0 after edge 3.
REQ-029 The bench SHALL cover: req=8'h92 in one cycle with ready=1 -> idx sequence 1,4,7 on consecutive cycles, with pending 8'h90, 8'h80, 8'h00.
REQ-030 The bench SHALL cover: valid=1, idx=3, ready=0 for 5 cycles, with req=8'h01 posted meanwhile -> idx stays 3; idx=0 appears the cycle after ready=1.
REQ-031 The bench SHALL cover: bit 5 pending and not selected, then req=8'h20 again -> overflow=1 for one cycle and bit 5 is granted only once.
REQ-032 The bench SHALL cover (REQ_ENCODER_ROUND_ROBIN_EN): req=8'hFF held 10 cycles with ready=1 -> idx 0,1,..,7,0,1; with the macro undefined, idx=0 every cycle.
REQ-033 The bench SHALL cover: reset_n pulsed low between clock edges while valid=1 and pending=8'h0C -> valid, idx, pending and overflow go to 0 immediately.
